// File: rtl/sdrc_app_dport.sv
// Application-side data port: a show-ahead write FIFO feeding the converter's app_wr_* beats
// and a read FIFO capturing app_rd_* words for the host, with burst-done pulses and sticky error flags.
module sdrc_app_dport #(
  parameter int APP_DW  = 32,
  parameter int APP_BW  = 4,
  parameter int FIFO_AW = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_in_valid,
  output logic                 wr_in_ready,
  input  logic [APP_DW-1:0]    wr_in_data,
  input  logic [APP_BW-1:0]    wr_in_be_n,
  output logic [APP_DW-1:0]    app_wr_data,
  output logic [APP_BW-1:0]    app_wr_en_n,
  input  logic                 app_wr_next,
  input  logic                 app_last_wr,
  input  logic [APP_DW-1:0]    app_rd_data,
  input  logic                 app_rd_valid,
  input  logic                 app_last_rd,
  output logic                 rd_out_valid,
  input  logic                 rd_out_ready,
  output logic [APP_DW-1:0]    rd_out_data,
  output logic                 rd_out_last,
  output logic [FIFO_AW:0]     wr_level,
  output logic [FIFO_AW:0]     rd_level,
  output logic                 wr_burst_done,
  output logic                 rd_burst_done,
  output logic                 wr_underrun,
  output logic                 rd_overflow,
  input  logic                 err_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  logic [APP_BW+APP_DW-1:0] r_wr_mem [DEPTH];
  logic [APP_DW:0]          r_rd_mem [DEPTH];

  logic [FIFO_AW-1:0] r_wr_wptr, r_wr_rptr, r_rd_wptr, r_rd_rptr;
  logic [FIFO_AW:0]   r_wr_level, r_rd_level;
  logic               r_wr_burst_done, r_rd_burst_done, r_wr_underrun, r_rd_overflow;

  logic w_wr_empty, w_wr_full, w_wr_push, w_wr_pop;
  logic w_rd_empty, w_rd_full, w_rd_push, w_rd_pop, w_rd_drop;
  logic [APP_BW+APP_DW-1:0] w_wr_head;
  logic [APP_DW:0]          w_rd_head;

  assign w_wr_empty = (r_wr_level == '0);
  assign w_wr_full  = (r_wr_level == LVL_FULL);
  assign w_wr_push  = wr_in_valid & ~w_wr_full;
  assign w_wr_pop   = app_wr_next & ~w_wr_empty;

  assign w_rd_empty = (r_rd_level == '0);
  assign w_rd_full  = (r_rd_level == LVL_FULL);
  assign w_rd_pop   = ~w_rd_empty & rd_out_ready;
  // A full read FIFO still takes the word when the host drains one in the same cycle.
  assign w_rd_push  = app_rd_valid & (~w_rd_full | w_rd_pop);
  assign w_rd_drop  = app_rd_valid & ~w_rd_push;

  assign w_wr_head = r_wr_mem[r_wr_rptr];
  assign w_rd_head = r_rd_mem[r_rd_rptr];

  assign wr_in_ready   = ~w_wr_full;
  assign app_wr_data   = w_wr_empty ? '0 : w_wr_head[APP_DW-1:0];
  assign app_wr_en_n   = w_wr_empty ? '1 : w_wr_head[APP_BW+APP_DW-1:APP_DW];
  assign rd_out_valid  = ~w_rd_empty;
  assign rd_out_data   = w_rd_head[APP_DW-1:0];
  assign rd_out_last   = ~w_rd_empty & w_rd_head[APP_DW];
  assign wr_level      = r_wr_level;
  assign rd_level      = r_rd_level;
  assign wr_burst_done = r_wr_burst_done;
  assign rd_burst_done = r_rd_burst_done;
  assign wr_underrun   = r_wr_underrun;
  assign rd_overflow   = r_rd_overflow;

  // Storage is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_push) r_wr_mem[r_wr_wptr] <= {wr_in_be_n, wr_in_data};
    if (w_rd_push) r_rd_mem[r_rd_wptr] <= {app_last_rd, app_rd_data};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_wptr       <= '0;
      r_wr_rptr       <= '0;
      r_rd_wptr       <= '0;
      r_rd_rptr       <= '0;
      r_wr_level      <= '0;
      r_rd_level      <= '0;
      r_wr_burst_done <= 1'b0;
      r_rd_burst_done <= 1'b0;
      r_wr_underrun   <= 1'b0;
      r_rd_overflow   <= 1'b0;
    end else begin
      if (w_wr_push) r_wr_wptr <= r_wr_wptr + PTR_ONE;
      if (w_wr_pop)  r_wr_rptr <= r_wr_rptr + PTR_ONE;
      if (w_rd_push) r_rd_wptr <= r_rd_wptr + PTR_ONE;
      if (w_rd_pop)  r_rd_rptr <= r_rd_rptr + PTR_ONE;

      if (w_wr_push && !w_wr_pop)      r_wr_level <= r_wr_level + LVL_ONE;
      else if (!w_wr_push && w_wr_pop) r_wr_level <= r_wr_level - LVL_ONE;

      if (w_rd_push && !w_rd_pop)      r_rd_level <= r_rd_level + LVL_ONE;
      else if (!w_rd_push && w_rd_pop) r_rd_level <= r_rd_level - LVL_ONE;

      r_wr_burst_done <= app_wr_next & app_last_wr;
      r_rd_burst_done <= w_rd_push & app_last_rd;

      if (err_clr)                        r_wr_underrun <= 1'b0;
      else if (app_wr_next && w_wr_empty) r_wr_underrun <= 1'b1;

      if (err_clr)        r_rd_overflow <= 1'b0;
      else if (w_rd_drop) r_rd_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdrc_app_dport.sv
// Bench for sdrc_app_dport: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a random traffic mix.
module tb_sdrc_app_dport;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_in_valid, wr_in_ready;
  logic [31:0] wr_in_data;
  logic [3:0]  wr_in_be_n;
  logic [31:0] app_wr_data;
  logic [3:0]  app_wr_en_n;
  logic        app_wr_next, app_last_wr;
  logic [31:0] app_rd_data;
  logic        app_rd_valid, app_last_rd;
  logic        rd_out_valid, rd_out_ready;
  logic [31:0] rd_out_data;
  logic        rd_out_last;
  logic [3:0]  wr_level, rd_level;
  logic        wr_burst_done, rd_burst_done, wr_underrun, rd_overflow, err_clr;

  sdrc_app_dport dut (
    .clk(clk), .reset_n(reset_n),
    .wr_in_valid(wr_in_valid), .wr_in_ready(wr_in_ready),
    .wr_in_data(wr_in_data), .wr_in_be_n(wr_in_be_n),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next(app_wr_next), .app_last_wr(app_last_wr),
    .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
    .rd_out_valid(rd_out_valid), .rd_out_ready(rd_out_ready),
    .rd_out_data(rd_out_data), .rd_out_last(rd_out_last),
    .wr_level(wr_level), .rd_level(rd_level),
    .wr_burst_done(wr_burst_done), .rd_burst_done(rd_burst_done),
    .wr_underrun(wr_underrun), .rd_overflow(rd_overflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] be_n; logic [31:0] d; } wr_ent_t;
  typedef struct { logic last; logic [31:0] d; } rd_ent_t;

  wr_ent_t wq[$];
  rd_ent_t rq[$];
  logic m_wbd = 0, m_rbd = 0, m_unr = 0, m_ovf = 0;
  bit   chk_en = 0;
  int   n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO occupancy is just the queue length, ordering is the queue order.
  always @(posedge clk) begin
    if (!reset_n) begin
      wq.delete(); rq.delete();
      m_wbd = 0; m_rbd = 0; m_unr = 0; m_ovf = 0;
    end else begin
      bit wpush, wpop, rpop, racc;
      wpush = wr_in_valid && (wq.size() < 8);
      wpop  = app_wr_next && (wq.size() > 0);
      rpop  = rd_out_ready && (rq.size() > 0);
      racc  = app_rd_valid && ((rq.size() < 8) || rpop);
      if (err_clr) m_unr = 0;
      else if (app_wr_next && wq.size() == 0) m_unr = 1;
      if (err_clr) m_ovf = 0;
      else if (app_rd_valid && !racc) m_ovf = 1;
      m_wbd = app_wr_next && app_last_wr;
      m_rbd = racc && app_last_rd;
      if (wpop) void'(wq.pop_front());
      if (wpush) wq.push_back('{be_n: wr_in_be_n, d: wr_in_data});
      if (rpop) void'(rq.pop_front());
      if (racc) rq.push_back('{last: app_last_rd, d: app_rd_data});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_in_ready", wr_in_ready, wq.size() < 8);
      chk("wr_level", wr_level, wq.size());
      chk("app_wr_data", app_wr_data, wq.size() > 0 ? wq[0].d : 32'h0);
      chk("app_wr_en_n", app_wr_en_n, wq.size() > 0 ? wq[0].be_n : 4'hF);
      chk("rd_level", rd_level, rq.size());
      chk("rd_out_valid", rd_out_valid, rq.size() > 0);
      if (rq.size() > 0) begin
        chk("rd_out_data", rd_out_data, rq[0].d);
        chk("rd_out_last", rd_out_last, rq[0].last);
      end else begin
        chk("rd_out_last_idle", rd_out_last, 1'b0);
      end
      chk("wr_burst_done", wr_burst_done, m_wbd);
      chk("rd_burst_done", rd_burst_done, m_rbd);
      chk("wr_underrun", wr_underrun, m_unr);
      chk("rd_overflow", rd_overflow, m_ovf);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_in_valid = 0; app_wr_next = 0; app_last_wr = 0;
    app_rd_valid = 0; app_last_rd = 0; rd_out_ready = 0; err_clr = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_in_ready", wr_in_ready, 1'b1);
    chk("rst_app_wr_data", app_wr_data, 32'h0);
    chk("rst_app_wr_en_n", app_wr_en_n, 4'hF);
    chk("rst_rd_out_valid", rd_out_valid, 1'b0);
    chk("rst_rd_out_last", rd_out_last, 1'b0);
    chk("rst_wr_level", wr_level, 4'd0);
    chk("rst_rd_level", rd_level, 4'd0);
    chk("rst_pulses", {wr_burst_done, rd_burst_done}, 2'b00);
    chk("rst_flags", {wr_underrun, rd_overflow}, 2'b00);
  endtask

  initial begin
    reset_n = 0; idle();
    wr_in_data = 0; wr_in_be_n = 0; app_rd_data = 0;
    tick(); tick();
    chk_en = 1;
    reset_n = 1;
    chk_reset_vals();

    // Write streaming
    for (int i = 0; i < 8; i++) begin
      wr_in_valid = 1; wr_in_data = 32'h11110000 + i; wr_in_be_n = 4'h0; tick();
    end
    wr_in_valid = 0;
    chk("ws_level8", wr_level, 4'd8);
    chk("ws_ready0", wr_in_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("ws_head", app_wr_data, 32'h11110000 + i);
      app_wr_next = 1; app_last_wr = (i == 7); tick();
    end
    app_wr_next = 0; app_last_wr = 0;
    chk("ws_burst_done", wr_burst_done, 1'b1);
    chk("ws_level0", wr_level, 4'd0);
    chk("ws_en_n_idle", app_wr_en_n, 4'hF);
    tick();
    chk("ws_burst_done_once", wr_burst_done, 1'b0);

    // Write full and underrun
    for (int i = 0; i < 9; i++) begin
      wr_in_valid = 1; wr_in_data = 32'h22220000 + i; wr_in_be_n = i[3:0]; tick();
    end
    wr_in_valid = 0;
    chk("wf_level8", wr_level, 4'd8);
    chk("wf_ready0", wr_in_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin app_wr_next = 1; tick(); end
    tick();
    chk("wf_unr", wr_underrun, 1'b1);
    chk("wf_level_stay0", wr_level, 4'd0);
    app_wr_next = 0; err_clr = 1; tick();
    err_clr = 0;
    chk("wf_unr_clr", wr_underrun, 1'b0);

    // Read burst
    rd_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      app_rd_valid = 1; app_rd_data = 32'hA0 + i; app_last_rd = (i == 3); tick();
      chk("rb_valid", rd_out_valid, 1'b1);
      chk("rb_data", rd_out_data, 32'hA0 + i);
      chk("rb_last", rd_out_last, i == 3);
    end
    chk("rb_done", rd_burst_done, 1'b1);
    app_rd_valid = 0; app_last_rd = 0; tick();
    chk("rb_done_once", rd_burst_done, 1'b0);
    chk("rb_empty", rd_out_valid, 1'b0);

    // Read overflow, then the same with a same-cycle pop on the 9th beat
    rd_out_ready = 0;
    for (int i = 0; i < 9; i++) begin app_rd_valid = 1; app_rd_data = 32'hB0 + i; tick(); end
    app_rd_valid = 0;
    chk("ro_level8", rd_level, 4'd8);
    chk("ro_ovf", rd_overflow, 1'b1);
    err_clr = 1; tick(); err_clr = 0;
    rd_out_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    rd_out_ready = 0;
    for (int i = 0; i < 8; i++) begin app_rd_valid = 1; app_rd_data = 32'hC0 + i; tick(); end
    app_rd_data = 32'hC8; rd_out_ready = 1; tick();
    app_rd_valid = 0; rd_out_ready = 0;
    chk("ro2_level8", rd_level, 4'd8);
    chk("ro2_no_ovf", rd_overflow, 1'b0);
    chk("ro2_head", rd_out_data, 32'hC1);
    rd_out_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    rd_out_ready = 0;

    // Reset mid-operation
    app_wr_next = 1; tick(); app_wr_next = 0;
    for (int i = 0; i < 9; i++) begin app_rd_valid = 1; app_rd_data = 32'hD0 + i; tick(); end
    app_rd_valid = 0; rd_out_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    rd_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      wr_in_valid = 1; wr_in_data = 32'h44440000 + i; wr_in_be_n = 4'h3; tick();
    end
    wr_in_valid = 0;
    chk("rm_pre_wr_level", wr_level, 4'd5);
    chk("rm_pre_rd_level", rd_level, 4'd3);
    chk("rm_pre_flags", {wr_underrun, rd_overflow}, 2'b11);
    reset_n = 0; tick(); reset_n = 1;
    chk_reset_vals();
    wr_in_valid = 1; wr_in_data = 32'h33330001; wr_in_be_n = 4'hA; tick();
    wr_in_valid = 0;
    chk("rm_head_data", app_wr_data, 32'h33330001);
    chk("rm_head_be", app_wr_en_n, 4'hA);
    app_wr_next = 1; tick(); app_wr_next = 0;

    // Concurrent random traffic
    for (int c = 0; c < 1000; c++) begin
      wr_in_valid  = $urandom_range(0, 1);
      wr_in_data   = $urandom;
      wr_in_be_n   = 4'($urandom_range(0, 15));
      app_wr_next  = ($urandom_range(0, 2) != 0);
      app_last_wr  = ($urandom_range(0, 5) == 0);
      app_rd_valid = $urandom_range(0, 1);
      app_rd_data  = $urandom;
      app_last_rd  = ($urandom_range(0, 3) == 0);
      rd_out_ready = ($urandom_range(0, 2) != 0);
      err_clr      = ($urandom_range(0, 40) == 0);
      tick();
    end
    idle();
    rd_out_ready = 1; app_wr_next = 1;
    for (int i = 0; i < 10; i++) tick();
    idle(); err_clr = 1; tick(); err_clr = 0;
    tick();
    chk("end_wr_level", wr_level, 4'd0);
    chk("end_rd_level", rd_level, 4'd0);
    chk("end_flags", {wr_underrun, rd_overflow}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sdrc_app_dport.md
# sdrc_app_dport

Application-side data port for the SDRAM controller. It is the peer of the buswidth converter's application interface. It sources `app_wr_data`/`app_wr_en_n` from a write FIFO on each `app_wr_next`, and it sinks `app_rd_data`/`app_rd_valid`/`app_last_rd` into a read FIFO. Each FIFO side faces a host valid/ready stream. The block sits between the host bus adapter and the converter, absorbs handshake mismatch, and flags protocol errors.

## Interface
- `APP_DW`, 32, application data width
- `APP_BW`, 4, application byte-enable width
- `FIFO_AW`, 3, FIFO address width; each FIFO holds 2^FIFO_AW entries

- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `wr_in_valid`  in  1  host write beat valid
- `wr_in_ready`  out  1  write FIFO can accept
- `wr_in_data`  in  APP_DW  host write data
- `wr_in_be_n`  in  APP_BW  host byte enables, active low
- `app_wr_data`  out  APP_DW  head of write FIFO
- `app_wr_en_n`  out  APP_BW  head byte enables; all-ones when FIFO is empty
- `app_wr_next`  in  1  controller consumes the head word
- `app_last_wr`  in  1  last write transfer of the burst
- `app_rd_data`  in  APP_DW  read word from the converter
- `app_rd_valid`  in  1  `app_rd_data` is valid
- `app_last_rd`  in  1  last read transfer of the burst
- `rd_out_valid`  out  1  read FIFO is non-empty
- `rd_out_ready`  in  1  host accepts the read head
- `rd_out_data`  out  APP_DW  read FIFO head data
- `rd_out_last`  out  1  head is the last word of its burst
- `wr_level`  out  FIFO_AW+1  write FIFO occupancy
- `rd_level`  out  FIFO_AW+1  read FIFO occupancy
- `wr_burst_done`  out  1  one-cycle pulse, write burst finished
- `rd_burst_done`  out  1  one-cycle pulse, last read word stored
- `wr_underrun`  out  1  sticky: `app_wr_next` arrived with the FIFO empty
- `rd_overflow`  out  1  sticky: read word dropped
- `err_clr`  in  1  clears both sticky flags

## Operation
- **Write FIFO**
  - Each entry is {be_n, data}, with show-ahead head.
  - Push: `wr_in_valid & wr_in_ready`.
  - `wr_in_ready` = !full, taken from the registered count. There is no push-through when full, even if a pop occurs in the same cycle.
- **Write head outputs**
  - Non-empty: `app_wr_data`/`app_wr_en_n` = head entry, combinational from the registered read pointer.
  - Empty: data = 0 and en_n = all ones, so a spurious beat writes nothing.
- **Write pop**
  - `app_wr_next` with the FIFO non-empty pops the head.
  - `app_wr_next` with the FIFO empty does not pop and sets `wr_underrun`.
- **`wr_burst_done`**
  - Pulses the cycle after `app_wr_next & app_last_wr`.
  - `app_last_wr` without `app_wr_next` is ignored.
- **Read FIFO**
  - Each entry is {last, data}, with last = `app_last_rd`.
  - Push on `app_rd_valid`. The push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the word is dropped and `rd_overflow` is set.
  - Pop: `rd_out_valid & rd_out_ready`.
- **`rd_burst_done`**
  - Pulses the cycle after an accepted push with `app_last_rd`=1.
  - A dropped last word sets `rd_overflow` only, with no pulse.
- **Pointers**
  - Pointers are FIFO_AW bits and wrap modulo 2^FIFO_AW.
  - Levels are FIFO_AW+1 bits.
  - Full: level = 2^FIFO_AW. Empty: level = 0.
  - Simultaneous push and pop leaves the level unchanged.
- **Error flags**
  - `err_clr` has priority over a same-cycle set event: the flag reads 0 next cycle.
- **Reset (`reset_n`=0 at an edge)**
  - Clears pointers, levels, pulses and sticky flags.
  - FIFO contents are not cleared. Any in-flight data is discarded, including data present mid-burst.

## Timing
- **Reset values**
  - `wr_in_ready`=1.
  - `app_wr_data`=0, `app_wr_en_n`=all ones.
  - `rd_out_valid`=0, `rd_out_data`=don't care, `rd_out_last`=0 (gated by valid).
  - `wr_level`=`rd_level`=0.
  - `wr_burst_done`=`rd_burst_done`=`wr_underrun`=`rd_overflow`=0.
- **Write latency**
  - A word pushed at edge N is the head at `app_wr_data` after edge N when the FIFO was empty, so it can be consumed in cycle N+1.
  - There is no combinational path from `wr_in_*` to `app_wr_*`.
- **Read latency**
  - `app_rd_valid` at edge N gives `rd_out_valid`=1 after edge N.
  - There is no combinational path from `app_rd_*` to `rd_out_*`.
- **Back-to-back traffic**
  - One push and one pop per FIFO per cycle are sustained indefinitely.
- **Counters and flags**
  - All flags and levels are registered and update on the edge following the event.

## Test plan
- **Write streaming:** push 8 words 0x11110000..0x11110007 with be_n=0; then assert `app_wr_next` for 8 consecutive cycles, with `app_last_wr` on the 8th. Required:
  - data is presented in order;
  - `wr_level` goes 8→0;
  - `wr_burst_done` pulses once, one cycle after the 8th beat;
  - `app_wr_en_n`=4'hF afterwards.
- **Write full and underrun:** push 9 words with FIFO_AW=3. Required:
  - `wr_in_ready`=0 after the 8th, and the 9th is held by the host;
  - drain 8, then one extra `app_wr_next`: `wr_underrun`=1 and `wr_level` stays 0;
  - `err_clr`: the flag reads 0 next cycle.
- **Read burst:** 4 `app_rd_valid` beats 0xA0..0xA3, with `app_last_rd` on 0xA3, and `rd_out_ready`=1. Required:
  - `rd_out_data` follows the same sequence with a 1-cycle delay;
  - `rd_out_last`=1 only with 0xA3;
  - `rd_burst_done` pulses once.
- **Read overflow:** `rd_out_ready`=0 while 9 read beats arrive. Required:
  - `rd_level`=8;
  - the 9th word is dropped and `rd_overflow`=1.
  - Repeat with `rd_out_ready`=1 in the 9th cycle: the word is accepted, `rd_level` stays 8 and there is no overflow.
- **Reset mid-operation:** with `wr_level`=5, `rd_level`=3 and both sticky flags set, pulse `reset_n`=0 for 1 cycle. Required:
  - every output returns to its reset value;
  - the next pushed word appears at the head.
- **Concurrent traffic:** a random 1000-cycle mix on all four handshakes. A scoreboard checks:
  - FIFO ordering;
  - level equals pushes minus pops;
  - no flag is set unless its trigger condition occurred.
